alu_bist: RTL and testbench

Built-in self-test engine for the RV32I integer ALU; it drives the ALU's operand/opcode inputs and checks its result and comparison flags. It sits beside the ALU in the execute stage and is muxed onto the ALU inputs during test. It steps a fixed 30-vector sequence (3 operand pairs × 10 ops) against an internal golden model and reports pass/fail, failure count and first failing vector.

---
 rtl/alu_pkg.sv | 90 +++++++++
 rtl/alu_golden.sv | 46 ++++
 rtl/alu_bist.sv | 185 ++++++++++++++++++
 tb/tb_alu_bist.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the RV32I ALU self-test engine.
//   - funct3/funct7 encodings of the ten register-register ALU ops
//   - op_e: op index 0..9 in the order the BIST steps through them
//   - bist_state_e: BIST controller states
//   - operand-pair constants and helpers mapping pair/op index to ALU inputs
package alu_pkg;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } bist_state_e;

  localparam int          NUM_PAIRS       = 3;
  localparam int          NUM_OPS         = 10;
  localparam int          NUM_VECTORS     = NUM_PAIRS * NUM_OPS;
  localparam logic [4:0]  LAST_VECTOR     = 5'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAST_OP         = 4'(NUM_OPS - 1);
  localparam logic [4:0]  FIRST_FAIL_NONE = 5'd31;
  localparam logic [5:0]  FAIL_COUNT_MAX  = 6'd63;

  // Operand pairs: small positives, negative vs positive, large +/- values.
  localparam logic [31:0] PAIR0_A = 32'd20;
  localparam logic [31:0] PAIR0_B = 32'd7;
  localparam logic [31:0] PAIR1_A = 32'hFFFF_FF9C;  // -100
  localparam logic [31:0] PAIR1_B = 32'd4;
  localparam logic [31:0] PAIR2_A = 32'd10000000;
  localparam logic [31:0] PAIR2_B = 32'hFF67_6980;  // -10000000

  function automatic logic [31:0] pair_a(input logic [1:0] p);
    case (p)
      2'd0:    return PAIR0_A;
      2'd1:    return PAIR1_A;
      default: return PAIR2_A;
    endcase
  endfunction

  function automatic logic [31:0] pair_b(input logic [1:0] p);
    case (p)
      2'd0:    return PAIR0_B;
      2'd1:    return PAIR1_B;
      default: return PAIR2_B;
    endcase
  endfunction

  function automatic logic [2:0] op_funct3(input op_e op);
    case (op)
      OP_ADD, OP_SUB: return F3_ADD_SUB;
      OP_SLL:         return F3_SLL;
      OP_SLT:         return F3_SLT;
      OP_SLTU:        return F3_SLTU;
      OP_XOR:         return F3_XOR;
      OP_SRL, OP_SRA: return F3_SRL_SRA;
      OP_OR:          return F3_OR;
      default:        return F3_AND;
    endcase
  endfunction

  function automatic logic [6:0] op_funct7(input op_e op);
    return (op == OP_SUB || op == OP_SRA) ? F7_ALT : F7_BASE;
  endfunction

endpackage

// File: rtl/alu_golden.sv
// alu_golden: combinational reference model of the RV32I integer ALU.
//   a, b     in   32  operands
//   op       in   op_e operation
//   res      out  32  result (32-bit wrap arithmetic, shifts by b[4:0])
//   eq, ge, less, ge_u, less_u  out  comparison flags of a vs b
module alu_golden
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  op_e         op,
  output logic [31:0] res,
  output logic        eq,
  output logic        ge,
  output logic        less,
  output logic        ge_u,
  output logic        less_u
);

  logic [4:0] shamt;

  assign shamt  = b[4:0];
  assign eq     = (a == b);
  assign less   = ($signed(a) < $signed(b));
  assign ge     = !less;
  assign less_u = (a < b);
  assign ge_u   = !less_u;

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLL:  res = a << shamt;
      OP_SLT:  res = {31'd0, less};
      OP_SLTU: res = {31'd0, less_u};
      OP_XOR:  res = a ^ b;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = $unsigned($signed(a) >>> shamt);
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test engine for the RV32I ALU.
// Steps 30 vectors (3 operand pairs x 10 ops), drives each onto the ALU,
// waits SETTLE_CYCLES, then compares result and flags with alu_golden.
//   clk, rst                 clock, async active-high reset
//   start                    begin a run (honoured only in IDLE/DONE)
//   alu_a, alu_b, alu_funct3, alu_funct7   registered ALU stimulus
//   alu_res1, alu_eq, alu_ge, alu_less, alu_ge_u, alu_less_u  ALU response
//   busy, done, pass         run status
//   fail_count               failing vectors this run (saturating)
//   first_fail               index of first failing vector, 31 if none
module alu_bist
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [31:0] alu_res1,
  input  logic        alu_eq,
  input  logic        alu_ge,
  input  logic        alu_less,
  input  logic        alu_ge_u,
  input  logic        alu_less_u,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  fail_count,
  output logic [4:0]  first_fail
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  bist_state_e state_reg, state_next;

  logic [4:0]       v_reg, v_next;
  logic [1:0]       p_reg, p_next;
  logic [3:0]       k_reg, k_next;
  logic [CNT_W-1:0] cnt_reg;

  logic restart;
  logic load_vec;
  logic sample_en;
  logic mismatch;

  op_e         op_cur;
  logic [31:0] g_res;
  logic        g_eq, g_ge, g_less, g_ge_u, g_less_u;

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_DRIVE;
      ST_DRIVE:         state_next = (SETTLE_CYCLES > 1) ? ST_WAIT : ST_SAMPLE;
      ST_WAIT:          if (cnt_reg == CNT_W'(1)) state_next = ST_SAMPLE;
      ST_SAMPLE:        state_next = (v_reg == LAST_VECTOR) ? ST_DONE : ST_DRIVE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // The stimulus registers load on the edge that enters DRIVE, so the
  // ALU inputs are already valid while the FSM sits in DRIVE.
  // ---------------------------------------------------------------
  always_comb begin
    busy      = (state_reg == ST_DRIVE) || (state_reg == ST_WAIT) ||
                (state_reg == ST_SAMPLE);
    done      = (state_reg == ST_DONE);
    pass      = done && (fail_count == 6'd0);
    restart   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    sample_en = (state_reg == ST_SAMPLE);
    load_vec  = (state_next == ST_DRIVE);
  end

  // Vector index bookkeeping: v = 10*p + k kept as three counters so the
  // pair/op selects need no divider.
  always_comb begin
    v_next = v_reg;
    p_next = p_reg;
    k_next = k_reg;
    if (restart) begin
      v_next = '0;
      p_next = '0;
      k_next = '0;
    end else if (sample_en && (v_reg != LAST_VECTOR)) begin
      v_next = v_reg + 5'd1;
      if (k_reg == LAST_OP) begin
        k_next = '0;
        p_next = p_reg + 2'd1;
      end else begin
        k_next = k_reg + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Golden compare against the vector currently on the ALU inputs
  // ---------------------------------------------------------------
  assign op_cur = op_e'(k_reg);

  alu_golden u_golden (
    .a      (alu_a),
    .b      (alu_b),
    .op     (op_cur),
    .res    (g_res),
    .eq     (g_eq),
    .ge     (g_ge),
    .less   (g_less),
    .ge_u   (g_ge_u),
    .less_u (g_less_u)
  );

  assign mismatch = (alu_res1 != g_res) ||
                    ({alu_eq, alu_ge, alu_less, alu_ge_u, alu_less_u} !=
                     {g_eq, g_ge, g_less, g_ge_u, g_less_u});

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg      <= '0;
      p_reg      <= '0;
      k_reg      <= '0;
      cnt_reg    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      fail_count <= '0;
      first_fail <= FIRST_FAIL_NONE;
    end else begin
      v_reg <= v_next;
      p_reg <= p_next;
      k_reg <= k_next;

      // Settle counter: loaded in DRIVE, counts down through WAIT.
      if (state_reg == ST_DRIVE) begin
        cnt_reg <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end

      // Stimulus holds its last value through DONE until the next DRIVE.
      if (load_vec) begin
        alu_a      <= pair_a(p_next);
        alu_b      <= pair_b(p_next);
        alu_funct3 <= op_funct3(op_e'(k_next));
        alu_funct7 <= op_funct7(op_e'(k_next));
      end

      if (restart) begin
        fail_count <= '0;
        first_fail <= FIRST_FAIL_NONE;
      end else if (sample_en && mismatch) begin
        if (fail_count != FAIL_COUNT_MAX) begin
          fail_count <= fail_count + 6'd1;
        end
        if (fail_count == 6'd0) begin
          first_fail <= v_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: self-checking bench for alu_bist.
// Two DUTs (SETTLE_CYCLES = 1 and 3) each drive a behavioural ALU with
// selectable fault injection. Driven vectors are checked against a queue of
// expected stimulus; end-of-run results against a table of expected outcomes.
module tb_alu_bist;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } vec_t;

  typedef struct {
    int dut;     // 0: SETTLE_CYCLES=1, 1: SETTLE_CYCLES=3
    int flt;     // 0 none, 1 sub acts as add, 2 less stuck 0, 3 less_u stuck 0
    bit extra;   // pulse start mid-run (must be ignored)
    int cycles;
    bit pass;
    int fc;
    int ff;
  } run_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start [2];
  int   fault;

  logic [31:0] alu_a [2];
  logic [31:0] alu_b [2];
  logic [2:0]  alu_funct3 [2];
  logic [6:0]  alu_funct7 [2];
  logic [31:0] alu_res1 [2];
  logic        alu_eq [2];
  logic        alu_ge [2];
  logic        alu_less [2];
  logic        alu_ge_u [2];
  logic        alu_less_u [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic [5:0]  fail_count [2];
  logic [4:0]  first_fail [2];

  // Behavioural ALU with fault injection; result packed as
  // {res, eq, ge, less, ge_u, less_u}.
  function automatic logic [36:0] alu_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0]  f3,
                                            input logic [6:0]  f7,
                                            input int          flt);
    logic [31:0] r;
    logic lt, ltu;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    case (f3)
      3'd0:    r = (f7 == 7'h20 && flt != 1) ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'd0, lt};
      3'd3:    r = {31'd0, ltu};
      3'd4:    r = a ^ b;
      3'd5:    r = (f7 == 7'h20) ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return {r, a == b, !lt, lt && (flt != 2), !ltu, ltu && (flt != 3)};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_bist #(.SETTLE_CYCLES((gi == 0) ? 1 : 3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[gi]),
      .alu_a      (alu_a[gi]),
      .alu_b      (alu_b[gi]),
      .alu_funct3 (alu_funct3[gi]),
      .alu_funct7 (alu_funct7[gi]),
      .alu_res1   (alu_res1[gi]),
      .alu_eq     (alu_eq[gi]),
      .alu_ge     (alu_ge[gi]),
      .alu_less   (alu_less[gi]),
      .alu_ge_u   (alu_ge_u[gi]),
      .alu_less_u (alu_less_u[gi]),
      .busy       (busy[gi]),
      .done       (done[gi]),
      .pass       (pass[gi]),
      .fail_count (fail_count[gi]),
      .first_fail (first_fail[gi])
    );

    always_comb begin
      {alu_res1[gi], alu_eq[gi], alu_ge[gi], alu_less[gi], alu_ge_u[gi], alu_less_u[gi]} =
        alu_model(alu_a[gi], alu_b[gi], alu_funct3[gi], alu_funct7[gi], fault);
    end
  end

  logic [31:0] tb_a  [3]  = '{32'd20, 32'hFFFF_FF9C, 32'd10000000};
  logic [31:0] tb_b  [3]  = '{32'd7, 32'd4, 32'hFF67_6980};
  logic [2:0]  tb_f3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  logic [6:0]  tb_f7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};

  vec_t exp_q [$];
  run_t res_q [$];
  run_t tbl [6];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Pulse start on DUT d, follow the run to done, checking each driven vector.
  task automatic run(input int d, input bit extra, output int cycles);
    int   s;
    int   vi;
    bit   seen;
    vec_t e;
    s = (d == 0) ? 1 : 3;
    for (int v = 0; v < 30; v++) begin
      exp_q.push_back('{tb_a[v / 10], tb_b[v / 10], tb_f3[v % 10], tb_f7[v % 10]});
    end
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    chk("busy_after_start", 32'(busy[d]), 32'd1);
    chk("done_after_start", 32'(done[d]), 32'd0);
    cycles = 0;
    seen   = 1'b0;
    vi     = 0;
    while (!seen && cycles < 400) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start[d] = extra && (cycles == 5 || cycles == 30);
      if (done[d]) begin
        seen = 1'b1;
      end else if ((cycles % (s + 1)) == s && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("vec%0d_a", vi),  alu_a[d], e.a);
        chk($sformatf("vec%0d_b", vi),  alu_b[d], e.b);
        chk($sformatf("vec%0d_f3", vi), 32'(alu_funct3[d]), 32'(e.f3));
        chk($sformatf("vec%0d_f7", vi), 32'(alu_funct7[d]), 32'(e.f7));
        chk($sformatf("vec%0d_busy", vi), 32'(busy[d]), 32'd1);
        if (d == 1 && fault == 0) begin
          if (vi == 2) chk("probe_sll", alu_res1[d], 32'd2560);
          if (vi == 5) chk("probe_xor", alu_res1[d], 32'd19);
          if (vi == 8) chk("probe_or",  alu_res1[d], 32'd23);
          if (vi == 9) chk("probe_and", alu_res1[d], 32'd4);
        end
        vi++;
      end
    end
    start[d] = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("vectors_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int   cyc;
    run_t r;

    tbl[0] = '{0, 0, 1'b0,  60, 1'b1,  0, 31};  // clean run from IDLE
    tbl[1] = '{0, 1, 1'b0,  60, 1'b0,  3,  1};  // restart from DONE; sub acts as add
    tbl[2] = '{0, 2, 1'b0,  60, 1'b0, 10, 10};  // less stuck 0
    tbl[3] = '{0, 3, 1'b0,  60, 1'b0, 10, 20};  // less_u stuck 0
    tbl[4] = '{0, 0, 1'b1,  60, 1'b1,  0, 31};  // mid-run start pulses ignored
    tbl[5] = '{1, 0, 1'b0, 120, 1'b1,  0, 31};  // SETTLE_CYCLES = 3

    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    fault    = 0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",       32'(busy[d]),       32'd0);
      chk("rst_done",       32'(done[d]),       32'd0);
      chk("rst_pass",       32'(pass[d]),       32'd0);
      chk("rst_fail_count", 32'(fail_count[d]), 32'd0);
      chk("rst_first_fail", 32'(first_fail[d]), 32'd31);
      chk("rst_alu_a",      alu_a[d],           32'd0);
      chk("rst_alu_funct7", 32'(alu_funct7[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fault = tbl[i].flt;
      res_q.push_back(tbl[i]);
      run(tbl[i].dut, tbl[i].extra, cyc);
      r = res_q.pop_front();
      chk("run_cycles",     32'(cyc),                32'(r.cycles));
      chk("run_pass",       32'(pass[r.dut]),        32'(r.pass));
      chk("run_fail_count", 32'(fail_count[r.dut]),  32'(r.fc));
      chk("run_first_fail", 32'(first_fail[r.dut]),  32'(r.ff));
      chk("run_busy_low",   32'(busy[r.dut]),        32'd0);
      $display("run %0d: settle=%0d fault=%0d cycles=%0d pass=%0d fail_count=%0d first_fail=%0d",
               i, (r.dut == 0) ? 1 : 3, r.flt, cyc, pass[r.dut], fail_count[r.dut], first_fail[r.dut]);
    end

    // Reset in the middle of a failing run: everything clears at once.
    fault = 1;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrun_fail_count", 32'(fail_count[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy",       32'(busy[0]),       32'd0);
    chk("midrun_rst_done",       32'(done[0]),       32'd0);
    chk("midrun_rst_fail_count", 32'(fail_count[0]), 32'd0);
    chk("midrun_rst_first_fail", 32'(first_fail[0]), 32'd31);
    chk("midrun_rst_alu_a",      alu_a[0],           32'd0);
    $display("reset mid-run: busy=%0d done=%0d fail_count=%0d first_fail=%0d",
             busy[0], done[0], fail_count[0], first_fail[0]);
    @(negedge clk);
    rst   = 1'b0;
    fault = 0;
    run(0, 1'b0, cyc);
    chk("post_rst_cycles",     32'(cyc),           32'd60);
    chk("post_rst_pass",       32'(pass[0]),       32'd1);
    chk("post_rst_fail_count", 32'(fail_count[0]), 32'd0);
    chk("post_rst_first_fail", 32'(first_fail[0]), 32'd31);
    $display("run after reset: cycles=%0d pass=%0d", cyc, pass[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
